msg_schedule: RTL and testbench



---
 rtl/msg_schedule.sv | 81 ++++++++
 tb/tb_msg_schedule.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule.sv
// SHA-256 message schedule expander: loads one 512-bit block and produces W[0..63],
// one new word per cycle, presented as a 2048-bit vector with W[0] in the top word.
module msg_schedule #(
   parameter bit BYTE_SWAP = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [511:0]  block_in,
   output logic [2047:0] schedule_out,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t               state;
   logic [5:0]           t;
   logic [63:0][31:0]    w;
   logic [15:0][31:0]    ldw;
   logic [31:0]          wnew;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Word k of the block sits at [511-32k -: 32]; optionally byte-reversed at load.
   for (genvar k = 0; k < 16; k++) begin : g_ld
      logic [31:0] wi;
      assign wi     = block_in[511-32*k -: 32];
      assign ldw[k] = BYTE_SWAP ? {wi[7:0], wi[15:8], wi[23:16], wi[31:24]} : wi;
   end

   for (genvar i = 0; i < 64; i++) begin : g_out
      assign schedule_out[2047-32*i -: 32] = w[i];
   end

   // All operands come from registered W; t-16..t-2 never wrap for t in 16..63.
   assign wnew = sig1(w[t - 6'd2]) + w[t - 6'd7] + sig0(w[t - 6'd15]) + w[t - 6'd16];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         t     <= '0;
         w     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  w[15:0] <= ldw;
                  t       <= 6'd16;
                  state   <= EXPAND;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            EXPAND: begin
               w[t] <= wnew;
               t    <= t + 6'd1;
               if (t == 6'd63) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_schedule.sv
// Bench for msg_schedule: a plain and a byte-swapping instance share start/reset and
// must both produce the reference schedule; expectations queue at start, pop at done.
module tb_msg_schedule;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [511:0]  blk0 = '0, blk1 = '0;
   logic [2047:0] so0, so1;
   logic          busy0, done0, busy1, done1;

   int total = 0;
   int bad   = 0;
   logic [2047:0] exp_q[$];

   typedef struct {
      string        name;
      logic [511:0] blk;
      logic [31:0]  w16;
      logic [31:0]  w17;
   } vec_t;

   always #5 clk = ~clk;

   msg_schedule #(.BYTE_SWAP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .block_in(blk0),
      .schedule_out(so0), .busy(busy0), .done(done0));

   msg_schedule #(.BYTE_SWAP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .block_in(blk1),
      .schedule_out(so1), .busy(busy1), .done(done1));

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [2047:0] ref_sched(input logic [511:0] b);
      logic [31:0]   w[64];
      logic [511:0]  bb;
      logic [2047:0] s;
      bb = b;
      s  = '0;
      for (int i = 0; i < 16; i++) begin
         w[i] = bb[511:480];
         bb   = bb << 32;
      end
      for (int i = 16; i < 64; i++)
         w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
      for (int i = 0; i < 64; i++)
         s = {s[2015:0], w[i]};
      return s;
   endfunction

   function automatic logic [511:0] bswap(input logic [511:0] b);
      logic [511:0] bb, r;
      logic [31:0]  x;
      bb = b;
      r  = '0;
      for (int i = 0; i < 16; i++) begin
         x  = bb[511:480];
         bb = bb << 32;
         r  = {r[479:0], x[7:0], x[15:8], x[23:16], x[31:24]};
      end
      return r;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_sched(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
      logic [2047:0] a, e;
      total++;
      if (act !== exp) begin
         bad++;
         a = act;
         e = exp;
         for (int i = 0; i < 64; i++) begin
            if (a[2047:2016] !== e[2047:2016]) begin
               $display("FAIL %s W[%0d] got=%h want=%h", nm, i, a[2047:2016], e[2047:2016]);
               break;
            end
            a = a << 32;
            e = e << 32;
         end
      end
   endtask

   // One full expansion: start pulse, timing checks, then scoreboard compare.
   task automatic run(input logic [511:0] b);
      int lat, nb;
      logic [2047:0] e;
      @(negedge clk);
      blk0  = b;
      blk1  = bswap(b);
      start = 1'b1;
      exp_q.push_back(ref_sched(b));
      @(posedge clk);
      #1;
      start = 1'b0;
      blk0  = rnd512();
      blk1  = rnd512();
      chk("start_done_drop", 32'(done0), 32'd0);
      chk("start_busy", 32'(busy0), 32'd1);
      lat = 1;
      nb  = busy0 ? 1 : 0;
      while (!done0 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy0) nb++;
      end
      chk("latency", 32'(lat), 32'd49);
      chk("busy_cycles", 32'(nb), 32'd48);
      chk("done_swap_inst", 32'(done1), 32'd1);
      e = exp_q.pop_front();
      chk_sched("sched_plain", so0, e);
      chk_sched("sched_swap", so1, e);
   endtask

   initial begin
      vec_t          v[4];
      logic [511:0]  b;
      logic [2047:0] e;
      bit            pd;
      int            ncomp, n;

      v[0].name = "zero";
      v[0].blk  = '0;
      v[0].w16  = 32'h0;
      v[0].w17  = 32'h0;
      v[1].name = "abc";
      v[1].blk  = {32'h61626380, 448'd0, 32'h00000018};
      v[1].w16  = 32'h61626380;
      v[1].w17  = 32'h000F0000;
      for (int i = 2; i < 4; i++) begin
         v[i].name = "random";
         v[i].blk  = rnd512();
         e         = ref_sched(v[i].blk);
         v[i].w16  = e[1535:1504];
         v[i].w17  = e[1503:1472];
      end

      #12;
      chk_sched("reset_sched_plain", so0, '0);
      chk_sched("reset_sched_swap", so1, '0);
      chk("reset_busy", 32'(busy0), 32'd0);
      chk("reset_done", 32'(done0), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         run(v[i].blk);
         chk({v[i].name, "_w16"}, so0[1535:1504], v[i].w16);
         chk({v[i].name, "_w17"}, so0[1503:1472], v[i].w17);
      end

      // Start held high: back-to-back expansions, garbage on block_in while busy.
      exp_q.delete();
      pd    = 1'b0;
      ncomp = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (!busy0) begin
            if (done0 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk_sched("b2b_plain", so0, e);
               chk_sched("b2b_swap", so1, e);
               ncomp++;
            end
            b    = rnd512();
            blk0 = b;
            blk1 = bswap(b);
            exp_q.push_back(ref_sched(b));
         end else begin
            blk0 = rnd512();
            blk1 = rnd512();
         end
         if (done0) chk("b2b_done_one_cycle", 32'(pd), 32'd0);
         pd = done0;
         @(negedge clk);
      end
      start = 1'b0;
      n = 0;
      while (!done0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_tail_done", 32'(done0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_sched("b2b_tail_plain", so0, e);
         chk_sched("b2b_tail_swap", so1, e);
      end
      chk("b2b_completions", 32'(ncomp), 32'd4);

      // Abort with reset once t reaches 30.
      exp_q.delete();
      @(negedge clk);
      b     = rnd512();
      blk0  = b;
      blk1  = bswap(b);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_sched("abort_sched_plain", so0, '0);
      chk_sched("abort_sched_swap", so1, '0);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_done", 32'(done0 | done1), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_abort_idle", 32'({busy0, done0}), 32'd0);
      run(rnd512());
      run(rnd512());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
